// File: rtl/bus_fabric_if.sv
// Lane request/return and target enable/data bundle for bus_fabric.
// slave is the fabric's view; master is the CPU-plus-targets view.
interface bus_fabric_if #(
   parameter int ADDRBITS = 15,
   parameter int NREGIONS = 3
);
   logic [ADDRBITS-1:0]   read_addr_even;
   logic [ADDRBITS-1:0]   read_addr_odd;
   logic                  read_en_even;
   logic                  read_en_odd;
   logic [ADDRBITS-1:0]   write_addr_even;
   logic [ADDRBITS-1:0]   write_addr_odd;
   logic                  write_en_even;
   logic                  write_en_odd;
   logic                  stall;
   logic [7:0]            read_data_even;
   logic [7:0]            read_data_odd;
   logic                  read_valid_even;
   logic                  read_valid_odd;
   logic [NREGIONS-1:0]   tgt_read_en_even;
   logic [NREGIONS-1:0]   tgt_read_en_odd;
   logic [NREGIONS-1:0]   tgt_write_en_even;
   logic [NREGIONS-1:0]   tgt_write_en_odd;
   logic [NREGIONS*8-1:0] tgt_read_data_even;
   logic [NREGIONS*8-1:0] tgt_read_data_odd;
   logic                  bus_err;
   logic [ADDRBITS-1:0]   err_addr;

   modport slave (
      input  read_addr_even, read_addr_odd, read_en_even, read_en_odd,
      input  write_addr_even, write_addr_odd, write_en_even, write_en_odd,
      input  tgt_read_data_even, tgt_read_data_odd,
      output stall, read_data_even, read_data_odd, read_valid_even, read_valid_odd,
      output tgt_read_en_even, tgt_read_en_odd, tgt_write_en_even, tgt_write_en_odd,
      output bus_err, err_addr
   );

   modport master (
      output read_addr_even, read_addr_odd, read_en_even, read_en_odd,
      output write_addr_even, write_addr_odd, write_en_even, write_en_odd,
      output tgt_read_data_even, tgt_read_data_odd,
      input  stall, read_data_even, read_data_odd, read_valid_even, read_valid_odd,
      input  tgt_read_en_even, tgt_read_en_odd, tgt_write_en_even, tgt_write_en_odd,
      input  bus_err, err_addr
   );
endinterface

// File: rtl/bus_fabric.sv
// Address decode, wait-state stall and read-return routing for the even/odd CPU lanes.
// Define BUS_FABRIC_ERRTRAP_EN to trap accesses below the first region base.
module bus_fabric #(
   parameter int                           ADDRBITS   = 15,
   parameter int                           NREGIONS   = 3,
   parameter logic [NREGIONS*ADDRBITS-1:0] REGIONBASE = {15'h4000, 15'h1000, 15'h0000},
   parameter logic [NREGIONS*4-1:0]        WAITSTATES = {4'd1, 4'd0, 4'd2}
) (
   input  logic        clk,
   input  logic        power_on_reset_n,
   bus_fabric_if.slave bus
);
   localparam int SELW = (NREGIONS > 1) ? $clog2(NREGIONS) : 1;

   // Access slots: 0 even read, 1 odd read, 2 even write, 3 odd write (also error priority order)
   logic [ADDRBITS-1:0] acc_addr   [4];
   logic [3:0]          acc_en;
   logic [SELW-1:0]     acc_sel    [4];
   logic [NREGIONS-1:0] acc_onehot [4];
   logic [3:0]          acc_mapped;
   logic [3:0]          w;
   logic [3:0]          cnt;
   logic [3:0]          cnt_next;
   logic                stall;
   logic                issue;
   logic [SELW-1:0]     sel_q_even;
   logic [SELW-1:0]     sel_q_odd;
   logic                valid_q_even;
   logic                valid_q_odd;
   logic                unm_q_even;
   logic                unm_q_odd;

   function automatic logic [SELW-1:0] region_of(input logic [ADDRBITS-1:0] addr);
      logic [SELW-1:0] idx;
      idx = '0;
      for (int i = 1; i < NREGIONS; i++) begin
         if (addr >= REGIONBASE[i*ADDRBITS +: ADDRBITS])
            idx = SELW'(i);
      end
      return idx;
   endfunction

   function automatic logic [3:0] region_wait(input logic [SELW-1:0] sel);
      return WAITSTATES[int'(sel)*4 +: 4];
   endfunction

   assign acc_addr[0] = bus.read_addr_even;
   assign acc_addr[1] = bus.read_addr_odd;
   assign acc_addr[2] = bus.write_addr_even;
   assign acc_addr[3] = bus.write_addr_odd;
   assign acc_en      = {bus.write_en_odd, bus.write_en_even, bus.read_en_odd, bus.read_en_even};

   // Decode every slot and take the worst-case wait over the active ones
   always_comb begin
      w = '0;
      for (int k = 0; k < 4; k++) begin
         acc_sel[k]    = region_of(acc_addr[k]);
         acc_onehot[k] = NREGIONS'(1) << acc_sel[k];
`ifdef BUS_FABRIC_ERRTRAP_EN
         acc_mapped[k] = (acc_addr[k] >= REGIONBASE[0 +: ADDRBITS]);
`else
         acc_mapped[k] = 1'b1;
`endif
         if (acc_en[k] && acc_mapped[k] && (region_wait(acc_sel[k]) > w))
            w = region_wait(acc_sel[k]);
      end
   end

   // Stall counter: loads w on a stalled request, issues on the cycle it reaches 1.
   // Reset also masks the combinational outputs so a held request cannot leak out.
   always_comb begin
      cnt_next = cnt;
      stall    = 1'b0;
      issue    = 1'b0;
      if (cnt == 4'd0) begin
         if (w == 4'd0) begin
            issue = 1'b1;
         end else begin
            stall    = 1'b1;
            cnt_next = w;
         end
      end else if (cnt == 4'd1) begin
         issue    = 1'b1;
         cnt_next = 4'd0;
      end else begin
         stall    = 1'b1;
         cnt_next = cnt - 4'd1;
      end
      if (!power_on_reset_n) begin
         stall = 1'b0;
         issue = 1'b0;
      end
   end

   assign bus.stall             = stall;
   assign bus.tgt_read_en_even  = (issue && acc_en[0] && acc_mapped[0]) ? acc_onehot[0] : '0;
   assign bus.tgt_read_en_odd   = (issue && acc_en[1] && acc_mapped[1]) ? acc_onehot[1] : '0;
   assign bus.tgt_write_en_even = (issue && acc_en[2] && acc_mapped[2]) ? acc_onehot[2] : '0;
   assign bus.tgt_write_en_odd  = (issue && acc_en[3] && acc_mapped[3]) ? acc_onehot[3] : '0;

   // Counter and per-lane return-routing registers
   always_ff @(posedge clk or negedge power_on_reset_n) begin
      if (!power_on_reset_n) begin
         cnt          <= '0;
         sel_q_even   <= '0;
         sel_q_odd    <= '0;
         valid_q_even <= 1'b0;
         valid_q_odd  <= 1'b0;
         unm_q_even   <= 1'b0;
         unm_q_odd    <= 1'b0;
      end else begin
         cnt          <= cnt_next;
         valid_q_even <= issue && acc_en[0];
         valid_q_odd  <= issue && acc_en[1];
         unm_q_even   <= issue && acc_en[0] && !acc_mapped[0];
         unm_q_odd    <= issue && acc_en[1] && !acc_mapped[1];
         if (issue && acc_en[0])
            sel_q_even <= acc_sel[0];
         if (issue && acc_en[1])
            sel_q_odd <= acc_sel[1];
      end
   end

   // Data is forced to zero outside valid cycles so idle and reset read back clean
   assign bus.read_valid_even = valid_q_even;
   assign bus.read_valid_odd  = valid_q_odd;
   assign bus.read_data_even  = !valid_q_even ? 8'h00 :
                                unm_q_even    ? 8'hff :
                                bus.tgt_read_data_even[int'(sel_q_even)*8 +: 8];
   assign bus.read_data_odd   = !valid_q_odd ? 8'h00 :
                                unm_q_odd    ? 8'hff :
                                bus.tgt_read_data_odd[int'(sel_q_odd)*8 +: 8];

`ifdef BUS_FABRIC_ERRTRAP_EN
   logic                err_any;
   logic [ADDRBITS-1:0] err_pick;
   logic                err_q;
   logic [ADDRBITS-1:0] err_addr_q;

   // Walk from lowest priority upward so the highest-priority unmapped slot wins
   always_comb begin
      err_any  = 1'b0;
      err_pick = '0;
      for (int k = 3; k >= 0; k--) begin
         if (acc_en[k] && !acc_mapped[k]) begin
            err_any  = 1'b1;
            err_pick = acc_addr[k];
         end
      end
   end

   always_ff @(posedge clk or negedge power_on_reset_n) begin
      if (!power_on_reset_n) begin
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         err_q <= issue && err_any;
         if (issue && err_any)
            err_addr_q <= err_pick;
      end
   end

   assign bus.bus_err  = err_q;
   assign bus.err_addr = err_addr_q;
`else
   assign bus.bus_err  = 1'b0;
   assign bus.err_addr = '0;
`endif
endmodule
